// File: rtl/minmax_pkg.sv
// Shared types and defaults for the min/max burst scanner.
package minmax_pkg;

  localparam int N_DEFAULT     = 4;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CMP_MAX,
    CMP_MIN,
    DONE
  } state_t;

  // Exactly one of lt/gt/eq is set for any operand pair
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_flags_t;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned N-bit magnitude comparator producing mutually exclusive lt/gt/eq flags.
module mag_cmp
  import minmax_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output cmp_flags_t   flags
);

  assign flags.lt = (a < b);
  assign flags.gt = (a > b);
  assign flags.eq = (a == b);

endmodule

// File: rtl/minmax_scan_ctrl.sv
// Burst min/max scanner: one comparator is shared between the running-max and
// running-min updates, so each word after the first costs three cycles.
module minmax_scan_ctrl
  import minmax_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               max_val,
  output logic [$clog2(DEPTH)-1:0]   max_idx,
  output logic [N-1:0]               min_val,
  output logic [$clog2(DEPTH)-1:0]   min_idx,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t        state;
  state_t        next_state;
  logic [N-1:0]  hold_data;
  logic          hold_last;
  logic [N-1:0]  cmp_b;
  cmp_flags_t    flags;
  logic          accept;
  logic [IW-1:0] cur_idx;
  logic          unused_eq;

  assign in_ready  = (state == IDLE) || (state == WAIT);
  assign accept    = in_valid && in_ready;
  assign cmp_b     = (state == CMP_MIN) ? min_val : max_val;
  assign cur_idx   = IW'(count - CW'(1));
  assign unused_eq = flags.eq;

  mag_cmp #(.N(N)) u_cmp (
    .a    (hold_data),
    .b    (cmp_b),
    .flags(flags)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = in_last ? DONE : WAIT;
      WAIT:    if (accept) next_state = CMP_MAX;
      CMP_MAX: next_state = CMP_MIN;
      CMP_MIN: next_state = (hold_last || (count == CW'(DEPTH))) ? DONE : WAIT;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Only strict gt/lt update the extremes, so ties keep the first occurrence
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_val   <= '0;
      max_idx   <= '0;
      min_val   <= '0;
      min_idx   <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            max_val <= in_data;
            min_val <= in_data;
            max_idx <= '0;
            min_idx <= '0;
            count   <= CW'(1);
          end
        end
        WAIT: begin
          if (accept) begin
            hold_data <= in_data;
            hold_last <= in_last;
            count     <= count + CW'(1);
          end
        end
        CMP_MAX: begin
          if (flags.gt) begin
            max_val <= hold_data;
            max_idx <= cur_idx;
          end
        end
        CMP_MIN: begin
          if (flags.lt) begin
            min_val <= hold_data;
            min_idx <= cur_idx;
          end
        end
        default: ;
      endcase
      out_valid <= (next_state == DONE);
    end
  end

endmodule
